// File: rtl/board_pkg.sv
// Shared definitions for the board game: state encodings (also used by the
// board generator), board geometry, the solved board and slot helpers.
package board_pkg;

  localparam int FIELD_W = 3;
  localparam int SLOTS   = 4;
  localparam int BOARD_W = FIELD_W * SLOTS;

  localparam logic [BOARD_W-1:0] SOLVED = 12'b000_001_010_011;

  typedef enum logic [1:0] {
    ST_CHOSE_BOARD  = 2'b00,
    ST_GAME_INITIAL = 2'b10,
    ST_GAMING       = 2'b01,
    ST_WINNED       = 2'b11
  } game_state_e;

  // Slot 0 occupies the most significant field.
  function automatic logic [FIELD_W-1:0] get_slot(input logic [BOARD_W-1:0] b,
                                                  input logic [1:0] idx);
    logic [FIELD_W-1:0] f;
    case (idx)
      2'd0:    f = b[11:9];
      2'd1:    f = b[8:6];
      2'd2:    f = b[5:3];
      default: f = b[2:0];
    endcase
    return f;
  endfunction

  function automatic logic [BOARD_W-1:0] set_slot(input logic [BOARD_W-1:0] b,
                                                  input logic [1:0] idx,
                                                  input logic [FIELD_W-1:0] v);
    logic [BOARD_W-1:0] r;
    r = b;
    case (idx)
      2'd0:    r[11:9] = v;
      2'd1:    r[8:6]  = v;
      2'd2:    r[5:3]  = v;
      default: r[2:0]  = v;
    endcase
    return r;
  endfunction

  // The 2-bit neighbour index wraps, so slot 3 pairs with slot 0.
  function automatic logic [BOARD_W-1:0] swap_slots(input logic [BOARD_W-1:0] b,
                                                    input logic [1:0] idx);
    logic [1:0] nxt;
    nxt = idx + 2'd1;
    return set_slot(set_slot(b, idx, get_slot(b, nxt)), nxt, get_slot(b, idx));
  endfunction

endpackage

// File: rtl/board_perm_check.sv
// Combinational check that a 12-bit board is a permutation of {0,1,2,3}.
module board_perm_check
  import board_pkg::*;
(
  input  logic [BOARD_W-1:0] i_board,
  output logic               o_valid
);

  logic [SLOTS-1:0]   w_seen;
  logic [FIELD_W-1:0] w_field;

  // With four fields, all below 4 and none repeated, every value appears once.
  always_comb begin
    w_seen  = '0;
    w_field = '0;
    o_valid = 1'b1;
    for (int i = 0; i < SLOTS; i++) begin
      w_field = get_slot(i_board, 2'(i));
      if (w_field[2]) begin
        o_valid = 1'b0;
      end else if (w_seen[w_field[1:0]]) begin
        o_valid = 1'b0;
      end else begin
        w_seen[w_field[1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_game_ctrl.sv
// Game-state owner and move engine. Single-level swap undo is built only when
// BOARD_UNDO_EN is defined; ports are identical in both builds.
module board_game_ctrl
  import board_pkg::*;
#(
  parameter int MOVE_W = 8
) (
  input  logic               clk_d,
  input  logic               rst,
  input  logic [BOARD_W-1:0] board_in,
  input  logic               btn_confirm,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_swap,
  input  logic               btn_undo,
  input  logic               btn_restart,
  output logic [1:0]         game_status,
  output logic [BOARD_W-1:0] board_out,
  output logic [1:0]         cursor,
  output logic [MOVE_W-1:0]  move_cnt,
  output logic               bad_board
);

  localparam logic [MOVE_W-1:0] CNT_ONE = MOVE_W'(1);
  localparam logic [MOVE_W-1:0] CNT_MAX = '1;

  game_state_e        r_state;
  logic [BOARD_W-1:0] r_board;
  logic [1:0]         r_cursor;
  logic [MOVE_W-1:0]  r_cnt;
  logic               r_bad;
  logic               w_perm_ok;

`ifdef BOARD_UNDO_EN
  logic               r_undo_valid;
  logic [1:0]         r_undo_cur;
  logic               r_undo_dec;
`else
  logic               w_undo_unused;
  assign w_undo_unused = btn_undo;
`endif

  board_perm_check u_perm_check (
    .i_board (board_in),
    .o_valid (w_perm_ok)
  );

  always_ff @(posedge clk_d) begin
    if (!rst) begin
      r_state  <= ST_CHOSE_BOARD;
      r_board  <= SOLVED;
      r_cursor <= 2'd0;
      r_cnt    <= '0;
      r_bad    <= 1'b0;
`ifdef BOARD_UNDO_EN
      r_undo_valid <= 1'b0;
      r_undo_cur   <= 2'd0;
      r_undo_dec   <= 1'b0;
`endif
    end else begin
      r_bad <= 1'b0;
      if (btn_restart) begin
        // Board is deliberately kept so the generator can show it again.
        r_state  <= ST_CHOSE_BOARD;
        r_cursor <= 2'd0;
        r_cnt    <= '0;
`ifdef BOARD_UNDO_EN
        r_undo_valid <= 1'b0;
`endif
      end else begin
        case (r_state)
          ST_CHOSE_BOARD: begin
            if (btn_confirm) begin
              if (w_perm_ok) begin
                r_board <= board_in;
                r_state <= ST_GAME_INITIAL;
              end else begin
                r_bad <= 1'b1;
              end
            end
          end
          ST_GAME_INITIAL: begin
            r_cursor <= 2'd0;
            r_cnt    <= '0;
            r_state  <= (r_board == SOLVED) ? ST_WINNED : ST_GAMING;
          end
          ST_GAMING: begin
            // Win is judged on the registered board; this cycle's buttons still act.
            if (r_board == SOLVED) begin
              r_state <= ST_WINNED;
            end
            if (btn_swap) begin
              r_board <= swap_slots(r_board, r_cursor);
              if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_ONE;
              end
`ifdef BOARD_UNDO_EN
              r_undo_valid <= 1'b1;
              r_undo_cur   <= r_cursor;
              r_undo_dec   <= (r_cnt != CNT_MAX);
`endif
            end
`ifdef BOARD_UNDO_EN
            else if (btn_undo && r_undo_valid) begin
              r_board      <= swap_slots(r_board, r_undo_cur);
              r_undo_valid <= 1'b0;
              if (r_undo_dec && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_ONE;
              end
            end
`endif
            else if (btn_left != btn_right) begin
              r_cursor <= btn_left ? (r_cursor - 2'd1) : (r_cursor + 2'd1);
            end
          end
          default: begin
            // WINNED: everything frozen until restart.
          end
        endcase
      end
    end
  end

  assign game_status = r_state;
  assign board_out   = r_board;
  assign cursor      = r_cursor;
  assign move_cnt    = r_cnt;
  assign bad_board   = r_bad;

endmodule

// File: tb/tb_board_game_ctrl.sv
// Directed scoreboard bench for board_game_ctrl; expectations depend on
// whether BOARD_UNDO_EN is defined for the build.
module tb_board_game_ctrl;

  localparam int MOVE_W = 8;
  localparam int W      = 31;

  localparam logic [11:0] B1023 = 12'b001_000_010_011;
  localparam logic [11:0] B0123 = 12'b000_001_010_011;
  localparam logic [11:0] BBAD  = 12'b000_000_010_011;
  localparam logic [11:0] B0132 = 12'b000_001_011_010;
  localparam logic [11:0] B2130 = 12'b010_001_011_000;
  localparam logic [11:0] B1032 = 12'b001_000_011_010;
  localparam logic [11:0] B1230 = 12'b001_010_011_000;

  // Button vector order: {confirm, left, right, swap, undo, restart}
  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] CONF  = 6'b100000;
  localparam logic [5:0] LEFT  = 6'b010000;
  localparam logic [5:0] RIGHT = 6'b001000;
  localparam logic [5:0] SWAP  = 6'b000100;
  localparam logic [5:0] UNDO  = 6'b000010;
  localparam logic [5:0] RST   = 6'b000001;

  localparam int F_ST = 0, F_BD = 1, F_CUR = 2, F_CNT = 3, F_BAD = 4;

`ifdef BOARD_UNDO_EN
  localparam bit UNDO_ON = 1'b1;
`else
  localparam bit UNDO_ON = 1'b0;
`endif

  logic              clk_d = 1'b0;
  logic              rst;
  logic [11:0]       board_in;
  logic              btn_confirm, btn_left, btn_right, btn_swap, btn_undo, btn_restart;
  logic [1:0]        game_status;
  logic [11:0]       board_out;
  logic [1:0]        cursor;
  logic [MOVE_W-1:0] move_cnt;
  logic              bad_board;

  logic [15:0]       cyc = '0;
  logic [W-1:0]      exp_q[$];
  int                n_cmp = 0;
  int                n_fail = 0;

  board_game_ctrl #(.MOVE_W(MOVE_W)) dut (
    .clk_d       (clk_d),
    .rst         (rst),
    .board_in    (board_in),
    .btn_confirm (btn_confirm),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_swap    (btn_swap),
    .btn_undo    (btn_undo),
    .btn_restart (btn_restart),
    .game_status (game_status),
    .board_out   (board_out),
    .cursor      (cursor),
    .move_cnt    (move_cnt),
    .bad_board   (bad_board)
  );

  // Clock and cycle counter
  always #5 clk_d = ~clk_d;
  always @(posedge clk_d) cyc <= cyc + 16'd1;

  function automatic string fname(input logic [2:0] f);
    case (f)
      3'd0:    return "game_status";
      3'd1:    return "board_out";
      3'd2:    return "cursor";
      3'd3:    return "move_cnt";
      default: return "bad_board";
    endcase
  endfunction

  function automatic logic [11:0] actual(input logic [2:0] f);
    case (f)
      3'd0:    return {10'd0, game_status};
      3'd1:    return board_out;
      3'd2:    return {10'd0, cursor};
      3'd3:    return {4'd0, move_cnt};
      default: return {11'd0, bad_board};
    endcase
  endfunction

  // Driver: present buttons for one rising edge, then release them.
  task automatic drive(input logic [5:0] b, input logic [11:0] bd);
    {btn_confirm, btn_left, btn_right, btn_swap, btn_undo, btn_restart} = b;
    board_in = bd;
    @(posedge clk_d);
    #1;
    {btn_confirm, btn_left, btn_right, btn_swap, btn_undo, btn_restart} = NONE;
  endtask

  // Expected value of a field for the outputs after the edge just driven.
  task automatic expect_f(input int f, input logic [11:0] v);
    logic [2:0] f3;
    f3 = 3'(f);
    exp_q.push_back({cyc, f3, v});
  endtask

  // Scoreboard monitor: samples on the falling edge.
  logic [W-1:0] mon_e;
  logic [11:0]  mon_act;
  always @(negedge clk_d) begin
    while (exp_q.size() != 0 && exp_q[0][30:15] <= cyc) begin
      mon_e   = exp_q.pop_front();
      mon_act = actual(mon_e[14:12]);
      n_cmp++;
      if (mon_e[30:15] != cyc || mon_act !== mon_e[11:0]) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got=%h want=%h", fname(mon_e[14:12]), cyc, mon_act,
                 mon_e[11:0]);
      end
    end
  end

  initial begin
    rst = 1'b0;
    board_in = '0;
    {btn_confirm, btn_left, btn_right, btn_swap, btn_undo, btn_restart} = NONE;
    repeat (2) @(posedge clk_d);
    #1;
    expect_f(F_ST, 12'd0); expect_f(F_BD, B0123); expect_f(F_CUR, 12'd0);
    expect_f(F_CNT, 12'd0); expect_f(F_BAD, 12'd0);
    rst = 1'b1;

    // Confirm a valid board, walk through GAME_INITIAL to GAMING
    drive(CONF, B1023); expect_f(F_ST, 12'h2); expect_f(F_BD, B1023);
    drive(NONE, B1023); expect_f(F_ST, 12'h1); expect_f(F_CUR, 12'd0); expect_f(F_CNT, 12'd0);

    // Winning swap, then registered win, then frozen
    drive(SWAP, B1023); expect_f(F_BD, B0123); expect_f(F_CNT, 12'd1); expect_f(F_ST, 12'h1);
    drive(NONE, B1023); expect_f(F_ST, 12'h3);
    drive(SWAP | RIGHT, B1023); expect_f(F_BD, B0123); expect_f(F_CUR, 12'd0);
    expect_f(F_CNT, 12'd1); expect_f(F_ST, 12'h3);
    drive(LEFT, B1023); expect_f(F_CUR, 12'd0);
    drive(RST | SWAP, B1023); expect_f(F_ST, 12'h0); expect_f(F_CNT, 12'd0);
    expect_f(F_CUR, 12'd0); expect_f(F_BD, B0123);

    // Rejected board
    drive(CONF, BBAD); expect_f(F_BAD, 12'd1); expect_f(F_ST, 12'h0); expect_f(F_BD, B0123);
    drive(RIGHT, BBAD); expect_f(F_BAD, 12'd0); expect_f(F_CUR, 12'd0); expect_f(F_ST, 12'h0);

    // Already-solved board goes straight to WINNED
    drive(CONF, B0123); expect_f(F_ST, 12'h2);
    drive(NONE, B0123); expect_f(F_ST, 12'h3);
    drive(RST, B0123); expect_f(F_ST, 12'h0);

    // Cursor wrap, swap across slot3/slot0, left+right cancel
    drive(CONF, B0132); expect_f(F_ST, 12'h2); expect_f(F_BD, B0132);
    drive(NONE, B0132); expect_f(F_ST, 12'h1);
    drive(LEFT, B0132); expect_f(F_CUR, 12'd3);
    drive(SWAP, B0132); expect_f(F_BD, B2130); expect_f(F_CNT, 12'd1); expect_f(F_CUR, 12'd3);
    drive(LEFT | RIGHT, B0132); expect_f(F_CUR, 12'd3);

    // Undo, second undo, then swap beats left
    drive(UNDO, B0132); expect_f(F_BD, UNDO_ON ? B0132 : B2130);
    expect_f(F_CNT, UNDO_ON ? 12'd0 : 12'd1);
    drive(UNDO, B0132); expect_f(F_BD, UNDO_ON ? B0132 : B2130);
    expect_f(F_CNT, UNDO_ON ? 12'd0 : 12'd1);
    drive(RIGHT, B0132); expect_f(F_CUR, 12'd0);
    drive(SWAP | LEFT, B0132); expect_f(F_CUR, 12'd0);
    expect_f(F_BD, UNDO_ON ? B1032 : B1230); expect_f(F_CNT, UNDO_ON ? 12'd1 : 12'd2);
    expect_f(F_ST, 12'h1);

    // Drive move_cnt to saturation
    for (int i = 0; i < (UNDO_ON ? 254 : 253); i++) drive(SWAP, B0132);
    expect_f(F_CNT, 12'd255); expect_f(F_BD, UNDO_ON ? B1032 : B2130);
    drive(SWAP, B0132); expect_f(F_CNT, 12'd255); expect_f(F_BD, UNDO_ON ? B0132 : B1230);
    drive(UNDO, B0132); expect_f(F_CNT, 12'd255); expect_f(F_BD, UNDO_ON ? B1032 : B1230);

    // Restart mid-GAMING clears history too
    drive(RST, B0132); expect_f(F_ST, 12'h0); expect_f(F_CNT, 12'd0); expect_f(F_CUR, 12'd0);
    expect_f(F_BD, UNDO_ON ? B1032 : B1230);
    drive(CONF, B0132); expect_f(F_ST, 12'h2); expect_f(F_BD, B0132);
    drive(NONE, B0132); expect_f(F_ST, 12'h1);
    drive(UNDO, B0132); expect_f(F_BD, B0132); expect_f(F_CNT, 12'd0);

    repeat (2) drive(NONE, B0132);
    @(negedge clk_d);
    #1;
    n_cmp++;
    if (game_status !== 2'b01) begin
      n_fail++;
      $display("FAIL final game_status got=%h want=1", game_status);
    end
    n_cmp++;
    if (board_out !== B0132) begin
      n_fail++;
      $display("FAIL final board_out got=%h want=%h", board_out, B0132);
    end
    n_cmp++;
    if (move_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL final move_cnt got=%h want=0", move_cnt);
    end
    n_cmp++;
    if (cursor !== 2'd0) begin
      n_fail++;
      $display("FAIL final cursor got=%h want=0", cursor);
    end
    n_cmp++;
    if (bad_board !== 1'b0) begin
      n_fail++;
      $display("FAIL final bad_board got=%h want=0", bad_board);
    end
    while (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL %s never_checked got=none want=%h", fname(mon_e[14:12]), mon_e[11:0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
